fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: BUS_DATA_WIDTH, 64, bus data width.
REQ-002 Parameter: BUS_TAG_WIDTH, 13, bus tag width.
REQ-003 Parameter: FIFO_DEPTH, 32, instruction FIFO entries (power of two, at least 16).
REQ-004 Port: clk, in, 1, sole clock; all state changes on its rising edge.
REQ-005 Port: reset, in, 1, asynchronous active-low reset.
REQ-006 Port: entry, in, 64, program entry address, sampled while reset is low.
REQ-007 Ports: bus_reqcyc out 1, bus_req out 64, bus_reqtag out 13, bus_reqack in 1; request channel.
REQ-008 Ports: bus_respcyc in 1, bus_resp in 64, bus_resptag in 13, bus_respack out 1; response channel.
REQ-009 Ports: instr_valid out 1, instr out 32, instr_pc out 64, instr_ready in 1; instruction channel to the decoder.
REQ-010 Port: halted, out 1, the zero-instruction terminator was fetched and the FIFO has drained.

Function
REQ-011 FSM states: IDLE, REQ, RESP, DONE.
REQ-012 IDLE -> REQ when FIFO occupancy <= FIFO_DEPTH-16; otherwise stays in IDLE.
REQ-013 REQ: bus_reqcyc=1, bus_req=pc, bus_reqtag={1'b1, SYSBUS_MEMORY, 8'b0}; all held stable until bus_reqack.
REQ-014 REQ -> RESP on the cycle bus_reqack=1; beat counter cleared; line base latched = pc; pc += 64.
REQ-015 RESP: bus_respack = bus_respcyc && (FIFO free >= 2); a beat counts as consumed only in a cycle where both are 1.
REQ-016 Consumed beat k (0..7): push bus_resp[31:0] with pc base+8k, then bus_resp[63:32] with pc base+8k+4; both pushed the same cycle; low half dequeues first.
REQ-017 Consumed beat equal to 64'h0: push nothing; set the sticky terminate flag; remaining beats of the line are acked but discarded.
REQ-018 After the 8th consumed beat: -> DONE if terminate is set, else -> IDLE.
REQ-019 DONE: no further requests; halted=1 once the FIFO is empty; state is left only by reset.
REQ-020 instr_valid = FIFO not empty; an entry pops when instr_valid && instr_ready; instr and instr_pc come from the FIFO head (first-word fall-through).
REQ-021 Simultaneous push and pop in one cycle are legal; occupancy never exceeds FIFO_DEPTH.
REQ-022 Read and write pointers wrap modulo FIFO_DEPTH; occupancy counter width is log2(FIFO_DEPTH)+1.
REQ-023 bus_resptag is ignored (single outstanding request).

Reset
REQ-024 While reset=0: state=IDLE, pc=entry, FIFO empty, pointers=0, terminate=0, beat counter=0.
REQ-025 While reset=0 all outputs are 0: bus_reqcyc, bus_respack, bus_req, bus_reqtag, instr_valid, instr, instr_pc, halted.
REQ-026 Reset asserted mid-line abandons the line; no partial line is retained after reset release.

Configuration
REQ-027 Macro FETCH_REDIRECT_EN adds inputs redirect_valid (1) and redirect_pc (64, 4-byte aligned).
REQ-028 With FETCH_REDIRECT_EN, redirect_valid flushes the FIFO and clears terminate the same cycle; in RESP, remaining beats are acked and discarded.
REQ-029 With FETCH_REDIRECT_EN, the next request goes to redirect_pc & ~63, and instructions below redirect_pc in that line are not pushed.
REQ-030 With FETCH_REDIRECT_EN, a redirect in REQ takes effect only after bus_reqack; a redirect in DONE returns the FSM to IDLE.
REQ-031 Without FETCH_REDIRECT_EN: no redirect ports or logic.

Structure
REQ-032 Package fetch_pkg holds the FSM state enum, LINE_BYTES=64, BEATS_PER_LINE=8, and the fetch tag constant.
REQ-033 Single sub-module fetch_fifo: synchronous FIFO with 2-wide push and 1-wide pop, 96-bit entries {pc, instr}.

Verification
REQ-034 entry=0x1000, ack after 2 cycles, 8 nonzero beats, instr_ready=1: 16 instructions out in order with pcs 0x1000..0x103C; second request at 0x1040.
REQ-035 instr_ready=0 throughout: bus_respack drops once FIFO free < 2; exactly 32 entries held; no beat lost after ready rises.
REQ-036 Beat 3 = 64'h0: 6 instructions delivered; beats 4-7 acked; no further request; halted=1 after the last pop.
REQ-037 reset=0 during beat 5: all outputs are 0 immediately; after release, a request at the new entry value; no stale instructions.
REQ-038 (FETCH_REDIRECT_EN) redirect_pc=0x2008 during RESP: FIFO flushed; next request at 0x2000; first instruction delivered has pc 0x2008.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional redirect support is enabled with the FETCH_REDIRECT_EN macro.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  localparam int LINE_BYTES     = 64;
  localparam int BEATS_PER_LINE = 8;

  localparam logic [3:0]  SYSBUS_MEMORY = 4'h1;
  localparam logic [12:0] FETCH_TAG     = {1'b1, SYSBUS_MEMORY, 8'b0};

endpackage

// File: rtl/fetch_fifo.sv
// Instruction FIFO: two-wide push, one-wide pop, first-word fall-through head.
// A push of a single entry may use either the low or the high lane.
module fetch_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 96,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_lo,
  input  logic             push_hi,
  input  logic [WIDTH-1:0] data_lo,
  input  logic [WIDTH-1:0] data_hi,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, wr_ptr_inc;
  logic [AW:0]      count_reg;
  logic [1:0]       n_push;
  logic             do_pop;
  logic [WIDTH-1:0] first_data;

  assign do_pop     = pop && (count_reg != '0);
  assign n_push     = {1'b0, push_lo} + {1'b0, push_hi};
  assign first_data = push_lo ? data_lo : data_hi;
  assign wr_ptr_inc = wr_ptr_reg + AW'(1);

  // Storage carries no reset; the head is qualified by the occupancy count.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (n_push != 2'd0) mem[wr_ptr_reg] <= first_data;
      if (n_push == 2'd2) mem[wr_ptr_inc] <= data_hi;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(n_push);
      rd_ptr_reg <= rd_ptr_reg + AW'(do_pop);
      count_reg  <= count_reg + (AW+1)'(n_push) - (AW+1)'(do_pop);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Line-based instruction fetch: requests 64-byte lines, splits beats into two
// 32-bit instructions and stops at an all-zero beat. FETCH_REDIRECT_EN adds redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      instr_valid,
  output logic [31:0]               instr,
  output logic [63:0]               instr_pc,
  input  logic                      instr_ready,
`ifdef FETCH_REDIRECT_EN
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
`endif
  output logic                      halted
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] REQ_LIMIT  = CW'(FIFO_DEPTH - 16);
  localparam logic [CW-1:0] RESP_LIMIT = CW'(FIFO_DEPTH - 2);
  localparam logic [63:0]   LINE_MASK  = ~64'(LINE_BYTES - 1);

  fetch_state_t  state_reg, state_next;
  logic [63:0]   pc_reg, pc_next, base_reg, base_next, beat_pc;
  logic [2:0]    beat_reg, beat_next;
  logic          term_reg, term_next;
  logic          discard, keep_lo, keep_hi;
  logic          flush, push_lo, push_hi;
  logic [95:0]   head;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_tag;

  // Only one request is ever outstanding, so the response tag carries no information.
  assign unused_tag = ^bus_resptag;

`ifdef FETCH_REDIRECT_EN
  logic        drop_reg, drop_next, pend_reg, pend_next;
  logic [63:0] min_pc_reg, min_pc_next, pend_pc_reg, pend_pc_next;
`endif

  assign beat_pc = base_reg + {58'b0, beat_reg, 3'b000};

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    base_next   = base_reg;
    beat_next   = beat_reg;
    term_next   = term_reg;
    bus_reqcyc  = 1'b0;
    bus_respack = 1'b0;
    push_lo     = 1'b0;
    push_hi     = 1'b0;
    flush       = 1'b0;
`ifdef FETCH_REDIRECT_EN
    drop_next    = drop_reg;
    min_pc_next  = min_pc_reg;
    pend_next    = pend_reg;
    pend_pc_next = pend_pc_reg;
    discard      = term_reg || drop_reg;
    keep_lo      = beat_pc >= min_pc_reg;
    keep_hi      = (beat_pc + 64'd4) >= min_pc_reg;
`else
    discard      = term_reg;
    keep_lo      = 1'b1;
    keep_hi      = 1'b1;
`endif

    case (state_reg)
      IDLE: if (fifo_count <= REQ_LIMIT) state_next = REQ;
      REQ: begin
        bus_reqcyc = 1'b1;
        if (bus_reqack) begin
          state_next = RESP;
          beat_next  = '0;
          base_next  = pc_reg;
          pc_next    = pc_reg + 64'(LINE_BYTES);
        end
      end
      RESP: begin
        bus_respack = bus_respcyc && (fifo_count <= RESP_LIMIT);
        if (bus_respack) begin
          if (!discard) begin
            if (bus_resp == '0) begin
              term_next = 1'b1;
            end else begin
              push_lo = keep_lo;
              push_hi = keep_hi;
            end
          end
          beat_next = beat_reg + 3'd1;
          if (beat_reg == 3'(BEATS_PER_LINE - 1)) state_next = term_next ? DONE : IDLE;
        end
      end
      default: ;
    endcase

`ifdef FETCH_REDIRECT_EN
    // A redirect seen while a request is in flight is applied at its acknowledge.
    if (state_reg == REQ && bus_reqack) begin
      drop_next = 1'b0;
      if (pend_reg || redirect_valid) begin
        drop_next   = 1'b1;
        pend_next   = 1'b0;
        pc_next     = (redirect_valid ? redirect_pc : pend_pc_reg) & LINE_MASK;
        min_pc_next = redirect_valid ? redirect_pc : pend_pc_reg;
      end
    end
    if (redirect_valid) begin
      flush     = 1'b1;
      term_next = 1'b0;
      push_lo   = 1'b0;
      push_hi   = 1'b0;
      case (state_reg)
        REQ: begin
          if (!bus_reqack) begin
            pend_next    = 1'b1;
            pend_pc_next = redirect_pc;
          end
        end
        RESP: begin
          drop_next   = 1'b1;
          pc_next     = redirect_pc & LINE_MASK;
          min_pc_next = redirect_pc;
          if (state_next == DONE) state_next = IDLE;
        end
        default: begin
          pc_next     = redirect_pc & LINE_MASK;
          min_pc_next = redirect_pc;
          if (state_reg == DONE) state_next = IDLE;
        end
      endcase
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      pc_reg    <= entry;
      base_reg  <= '0;
      beat_reg  <= '0;
      term_reg  <= 1'b0;
`ifdef FETCH_REDIRECT_EN
      drop_reg    <= 1'b0;
      min_pc_reg  <= '0;
      pend_reg    <= 1'b0;
      pend_pc_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      base_reg  <= base_next;
      beat_reg  <= beat_next;
      term_reg  <= term_next;
`ifdef FETCH_REDIRECT_EN
      drop_reg    <= drop_next;
      min_pc_reg  <= min_pc_next;
      pend_reg    <= pend_next;
      pend_pc_reg <= pend_pc_next;
`endif
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(96)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .push_lo(push_lo),
    .push_hi(push_hi),
    .data_lo({beat_pc, bus_resp[31:0]}),
    .data_hi({beat_pc + 64'd4, bus_resp[63:32]}),
    .pop    (instr_ready),
    .head   (head),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign bus_req     = (state_reg == REQ) ? BUS_DATA_WIDTH'(pc_reg) : '0;
  assign bus_reqtag  = (state_reg == REQ) ? BUS_TAG_WIDTH'(FETCH_TAG) : '0;
  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? 32'h0 : head[31:0];
  assign instr_pc    = fifo_empty ? 64'h0 : head[95:32];
  assign halted      = (state_reg == DONE) && fifo_empty;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bus responder, sequential-pc instruction model
// and hand-computed expectations; FETCH_REDIRECT_EN adds a redirect scenario.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] entry = 64'h0;
  logic        bus_reqcyc, bus_respack, instr_valid, halted;
  logic [63:0] bus_req, instr_pc;
  logic [12:0] bus_reqtag;
  logic [31:0] instr;
  logic        bus_reqack = 1'b0, bus_respcyc = 1'b0, instr_ready = 1'b0;
  logic [63:0] bus_resp = 64'h0;
  logic [12:0] bus_resptag = 13'h0;
`ifdef FETCH_REDIRECT_EN
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .FIFO_DEPTH(32)) dut (
    .clk(clk), .reset(reset), .entry(entry),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
`ifdef FETCH_REDIRECT_EN
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`endif
    .halted(halted)
  );

  int tests = 0, fails = 0;
  int pops = 0, reqs = 0, beats = 0;
  int rsp_st = 0, wcnt = 0, k = 0;
  logic        ack_seen;
  logic [63:0] zero_addr = '1;
  logic [63:0] exp_pc, exp_req, line_addr;
  logic [63:0] first_pc, pc16, last_pc, first_req, last_req;
  logic [31:0] first_instr, instr16;

  // Memory image: every 8-byte beat is nonzero except the one at zero_addr.
  function automatic logic [63:0] mem_beat(input logic [63:0] a);
    if (a == zero_addr) return 64'h0;
    return {32'hBEEF_0000 ^ (a[31:0] + 32'd4), 32'hC0DE_0000 ^ a[31:0]};
  endfunction

  function automatic logic [31:0] model_instr(input logic [63:0] pc);
    return pc[2] ? (32'hBEEF_0000 ^ pc[31:0]) : (32'hC0DE_0000 ^ pc[31:0]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  // Instruction-stream compare on the falling edge, bus responder after the rising edge.
  always begin
    @(negedge clk);
    ack_seen = bus_respack;
    if (!reset) begin
      exp_pc  = entry;
      exp_req = entry & ~64'h3F;
      pops = 0; reqs = 0; beats = 0;
    end else begin
      if (instr_valid && instr_ready) begin
        tests++;
        if (exp_pc >= zero_addr || instr_pc !== exp_pc || instr !== model_instr(exp_pc)) begin
          fails++;
          $display("FAIL pop%0d: got pc=%h instr=%h, required pc=%h instr=%h (limit %h)",
                   pops, instr_pc, instr, exp_pc, model_instr(exp_pc), zero_addr);
        end else begin
          $display("[TB] pop pc=%h instr=%h", instr_pc, instr);
        end
        if (pops == 0) begin first_pc = instr_pc; first_instr = instr; end
        if (pops == 15) begin pc16 = instr_pc; instr16 = instr; end
        last_pc = instr_pc;
        exp_pc  = exp_pc + 64'd4;
        pops++;
      end
`ifdef FETCH_REDIRECT_EN
      if (redirect_valid) begin
        exp_pc  = redirect_pc;
        exp_req = redirect_pc & ~64'h3F;
      end
`endif
    end

    @(posedge clk); #1;
    if (!reset) begin
      rsp_st = 0; wcnt = 0; k = 0;
      bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = 64'h0;
    end else begin
      case (rsp_st)
        0: begin
          bus_reqack = 1'b0;
          if (bus_reqcyc) begin
            wcnt++;
            if (wcnt == 3) begin
              tests++;
              if (bus_req !== exp_req || bus_reqtag !== 13'h1100) begin
                fails++;
                $display("FAIL req%0d: got addr=%h tag=%h, required addr=%h tag=1100",
                         reqs, bus_req, bus_reqtag, exp_req);
              end else begin
                $display("[TB] req addr=%h tag=%h", bus_req, bus_reqtag);
              end
              if (reqs == 0) first_req = bus_req;
              last_req   = bus_req;
              line_addr  = bus_req;
              exp_req    = exp_req + 64'd64;
              reqs++;
              wcnt       = 0;
              bus_reqack = 1'b1;
              rsp_st     = 1;
            end
          end
        end
        1: begin
          bus_reqack  = 1'b0;
          k           = 0;
          bus_respcyc = 1'b1;
          bus_resp    = mem_beat(line_addr);
          rsp_st      = 2;
        end
        default: begin
          if (ack_seen) begin
            beats++;
            k++;
            if (k == 8) begin
              bus_respcyc = 1'b0;
              bus_resp    = 64'h0;
              rsp_st      = 0;
            end else begin
              bus_resp = mem_beat(line_addr + 64'(8 * k));
            end
          end
        end
      endcase
    end
  end

  task automatic do_reset(input logic [63:0] e, input logic [63:0] z);
    @(posedge clk); #2;
    reset = 1'b0; entry = e; zero_addr = z; instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    // Reset state
    entry = 64'h1000;
    repeat (3) @(posedge clk);
    #2;
    check("rst_reqcyc", bus_reqcyc, 0);
    check("rst_respack", bus_respack, 0);
    check("rst_req", bus_req, 0);
    check("rst_reqtag", bus_reqtag, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_halted", halted, 0);

    // Straight-line fetch from 0x1000
    do_reset(64'h1000, '1);
    instr_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (pops >= 16 && reqs >= 2) break;
      @(posedge clk); #2;
    end
    check("A_progress", 64'(pops >= 16 && reqs >= 2), 1);
    check("A_first_pc", first_pc, 64'h1000);
    check("A_first_instr", first_instr, 32'hC0DE_1000);
    check("A_pc16", pc16, 64'h103C);
    check("A_instr16", instr16, 32'hBEEF_103C);
    check("A_second_req", last_req, 64'h1040);
    check("A_halted", halted, 0);

    // Decoder stalled: FIFO fills to capacity, then drains without loss
    do_reset(64'h3000, '1);
    repeat (300) @(posedge clk);
    #2;
    check("B_beats_full", beats, 16);
    check("B_reqs_full", reqs, 2);
    check("B_pops_full", pops, 0);
    check("B_valid_full", instr_valid, 1);
    check("B_reqcyc_full", bus_reqcyc, 0);
    check("B_head_pc", instr_pc, 64'h3000);
    instr_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (pops >= 32 && reqs >= 3) break;
      @(posedge clk); #2;
    end
    check("B_drain", 64'(pops >= 32 && reqs >= 3), 1);

    // Zero beat at beat 3 terminates fetch
    do_reset(64'h4000, 64'h4018);
    instr_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (halted) break;
      @(posedge clk); #2;
    end
    repeat (50) @(posedge clk);
    #2;
    check("C_halted", halted, 1);
    check("C_pops", pops, 6);
    check("C_last_pc", last_pc, 64'h4014);
    check("C_beats", beats, 8);
    check("C_reqs", reqs, 1);
    check("C_reqcyc", bus_reqcyc, 0);

    // Reset in the middle of a line
    do_reset(64'h5000, '1);
    for (int i = 0; i < 200; i++) begin
      if (rsp_st == 2 && k == 5) break;
      @(posedge clk); #2;
    end
    check("D_at_beat5", 64'(rsp_st == 2 && k == 5), 1);
    reset = 1'b0;
    #1;
    check("D_reqcyc", bus_reqcyc, 0);
    check("D_respack", bus_respack, 0);
    check("D_req", bus_req, 0);
    check("D_reqtag", bus_reqtag, 0);
    check("D_valid", instr_valid, 0);
    check("D_instr", instr, 0);
    check("D_pc", instr_pc, 0);
    check("D_halted", halted, 0);
    entry = 64'h6000;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (pops >= 20) break;
      @(posedge clk); #2;
    end
    check("D_pops", 64'(pops >= 20), 1);
    check("D_first_req", first_req, 64'h6000);
    check("D_first_pc", first_pc, 64'h6000);

`ifdef FETCH_REDIRECT_EN
    // Redirect during a response
    do_reset(64'h1000, '1);
    for (int i = 0; i < 200; i++) begin
      if (rsp_st == 2 && k == 2) break;
      @(posedge clk); #2;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2008;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    @(negedge clk); #1;
    check("E_flushed", instr_valid, 0);
    instr_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (pops >= 4) break;
      @(posedge clk); #2;
    end
    check("E_pops", 64'(pops >= 4), 1);
    check("E_req", last_req, 64'h2000);
    check("E_first_pc", first_pc, 64'h2008);
    check("E_first_instr", first_instr, 32'hC0DE_2008);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
